// File: rtl/sub_pkg.sv
// Shared widths and the stage-1 register set for the two-stage 32-bit subtractor.
package sub_pkg;
  localparam int WORD_W = 32;
  localparam int HALF_W = 16;

  typedef struct packed {
    logic [HALF_W-1:0] lo_diff;
    logic              c16;
    logic [HALF_W-1:0] a_hi;
    logic [HALF_W-1:0] b_hi;
  } s1_t;
endpackage

// File: rtl/subtractor_32bit_if.sv
// Operand/result handshake bundle: valid/ready in, valid/ready out, difference and flags.
interface subtractor_32bit_if;
  import sub_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] A;
  logic [WORD_W-1:0] B;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] D;
  logic              B32;
  logic              V;
  logic              Z;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, D, B32, V, Z
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, D, B32, V, Z
  );
endinterface

// File: rtl/sub_slice_16.sv
// Combinational 16-bit slice computing a + ~b + cin with carry out.
module sub_slice_16
  import sub_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              cin,
  output logic [HALF_W-1:0] diff,
  output logic              cout
);
  assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + {{HALF_W{1'b0}}, cin};
endmodule

// File: rtl/subtractor_32bit.sv
// Two-stage 32-bit subtractor: low half in stage 1, high half and flags in stage 2.
// Result appears one edge after accept; stalls hold outputs and drop in_ready once both stages are full.
module subtractor_32bit
  import sub_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  subtractor_32bit_if.slave   bus
);
  s1_t               s1_q, s1_d;
  logic              s1_valid_q;
  logic              out_valid_q;
  logic [WORD_W-1:0] d_q, d_d;
  logic              b32_q, b32_d;
  logic              v_q, v_d;
  logic              z_q, z_d;

  logic [HALF_W-1:0] lo_diff, hi_diff;
  logic              c16, c32;
  logic              s2_adv, accept;

  sub_slice_16 u_lo (
    .a    (bus.A[HALF_W-1:0]),
    .b    (bus.B[HALF_W-1:0]),
    .cin  (1'b1),
    .diff (lo_diff),
    .cout (c16)
  );

  sub_slice_16 u_hi (
    .a    (s1_q.a_hi),
    .b    (s1_q.b_hi),
    .cin  (s1_q.c16),
    .diff (hi_diff),
    .cout (c32)
  );

  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || s2_adv;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    s1_d.lo_diff = lo_diff;
    s1_d.c16     = c16;
    s1_d.a_hi    = bus.A[WORD_W-1:HALF_W];
    s1_d.b_hi    = bus.B[WORD_W-1:HALF_W];
    d_d          = {hi_diff, s1_q.lo_diff};
    b32_d        = ~c32;
    // Overflow only possible when operand signs differ.
    v_d          = (s1_q.a_hi[HALF_W-1] != s1_q.b_hi[HALF_W-1]) &&
                   (hi_diff[HALF_W-1] != s1_q.a_hi[HALF_W-1]);
    z_d          = (d_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      b32_q       <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b1;
    end else begin
      if (accept) begin
        s1_q       <= s1_d;
        s1_valid_q <= 1'b1;
      end else if (s2_adv) begin
        s1_valid_q <= 1'b0;
      end

      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        // Data only loads with a real result so it holds while idle.
        if (s1_valid_q) begin
          d_q   <= d_d;
          b32_q <= b32_d;
          v_q   <= v_d;
          z_q   <= z_d;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.D         = d_q;
  assign bus.B32       = b32_q;
  assign bus.V         = v_q;
  assign bus.Z         = z_q;
endmodule

// File: tb/tb_subtractor_32bit.sv
// Directed vector bench for subtractor_32bit: latency, streaming, backpressure and reset flush.
module tb_subtractor_32bit;
  import sub_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        b32;
    logic        v;
    logic        z;
  } vec_t;

  localparam int NV = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs [NV];

  subtractor_32bit_if bus ();

  subtractor_32bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then settle before sampling.
  task automatic tick(input logic rst, input logic iv, input logic [31:0] a,
                      input logic [31:0] b, input logic ordy);
    @(negedge clk);
    rst_n         = rst;
    bus.in_valid  = iv;
    bus.A         = a;
    bus.B         = b;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic chk_result(input string name, input int i);
    chk(name, {29'd0, bus.D, bus.B32, bus.V, bus.Z},
        {29'd0, vecs[i].d, vecs[i].b32, vecs[i].v, vecs[i].z});
  endtask

  initial begin
    vecs[0] = '{32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h1234ABCD, 32'h1234ABCD, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h12345678, 32'h87654321, 32'h8ACF1357, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{32'h00000000, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0};

    // Reset state
    for (int c = 0; c < 3; c++) tick(1'b0, 1'b0, '0, '0, 1'b1);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_result", {29'd0, bus.D, bus.B32, bus.V, bus.Z}, {29'd0, 32'h0, 1'b0, 1'b0, 1'b1});
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // One operand at a time: accept, one empty cycle, then the result
    for (int i = 0; i < NV; i++) begin
      tick(1'b1, 1'b1, vecs[i].a, vecs[i].b, 1'b1);
      chk($sformatf("dir%0d_in_ready", i), {63'd0, bus.in_ready}, 64'd1);
      tick(1'b1, 1'b0, '0, '0, 1'b1);
      chk($sformatf("dir%0d_early_valid", i), {63'd0, bus.out_valid}, 64'd0);
      tick(1'b1, 1'b0, '0, '0, 1'b1);
      chk($sformatf("dir%0d_out_valid", i), {63'd0, bus.out_valid}, 64'd1);
      chk_result($sformatf("dir%0d_res", i), i);
    end
    tick(1'b1, 1'b0, '0, '0, 1'b1);
    chk("idle_hold", {29'd0, bus.D, bus.B32, bus.V, bus.Z},
        {29'd0, vecs[NV-1].d, vecs[NV-1].b32, vecs[NV-1].v, vecs[NV-1].z});

    // Back-to-back stream: one result per cycle, in order
    for (int c = 0; c < NV + 3; c++) begin
      if (c < NV) tick(1'b1, 1'b1, vecs[c].a, vecs[c].b, 1'b1);
      else        tick(1'b1, 1'b0, '0, '0, 1'b1);
      if (c < NV) chk($sformatf("stream%0d_in_ready", c), {63'd0, bus.in_ready}, 64'd1);
      if (c >= 2 && c < NV + 2) begin
        chk($sformatf("stream%0d_out_valid", c - 2), {63'd0, bus.out_valid}, 64'd1);
        chk_result($sformatf("stream%0d_res", c - 2), c - 2);
      end
    end
    chk("stream_drained", {63'd0, bus.out_valid}, 64'd0);

    // Backpressure: out_ready low for cycles 0..4, four operands offered
    begin
      int idx = 0;
      int accepts = 0;
      for (int c = 0; c < 10; c++) begin
        if (idx < 4) tick(1'b1, 1'b1, vecs[idx].a, vecs[idx].b, (c >= 5));
        else         tick(1'b1, 1'b0, '0, '0, (c >= 5));
        if (c >= 2 && c <= 4) begin
          chk($sformatf("bp_c%0d_in_ready", c), {63'd0, bus.in_ready}, 64'd0);
          chk($sformatf("bp_c%0d_out_valid", c), {63'd0, bus.out_valid}, 64'd1);
          chk_result($sformatf("bp_c%0d_hold", c), 0);
        end
        if (c == 2) chk("bp_accepts", 64'(accepts), 64'd2);
        if (c >= 5 && c <= 8) begin
          chk($sformatf("bp_out%0d_valid", c - 5), {63'd0, bus.out_valid}, 64'd1);
          chk_result($sformatf("bp_out%0d_res", c - 5), c - 5);
        end
        if (c == 9) chk("bp_drained", {63'd0, bus.out_valid}, 64'd0);
        if (bus.in_valid && bus.in_ready) begin
          accepts++;
          idx++;
        end
      end
      chk("bp_total_accepts", 64'(accepts), 64'd4);
    end

    // Reset with both stages full discards everything
    tick(1'b1, 1'b1, vecs[4].a, vecs[4].b, 1'b0);
    tick(1'b1, 1'b1, vecs[5].a, vecs[5].b, 1'b0);
    tick(1'b0, 1'b0, '0, '0, 1'b0);
    chk("full_out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
    tick(1'b1, 1'b0, '0, '0, 1'b1);
    chk("rst2_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst2_result", {29'd0, bus.D, bus.B32, bus.V, bus.Z}, {29'd0, 32'h0, 1'b0, 1'b0, 1'b1});
    chk("rst2_in_ready", {63'd0, bus.in_ready}, 64'd1);
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, 1'b0, '0, '0, 1'b1);
      chk($sformatf("rst2_no_stale%0d", c), {63'd0, bus.out_valid}, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/subtractor_32bit.md
SUBTRACTOR_32BIT -- requirements
Module: subtractor_32bit

Interface
REQ-001 Parameters: none; all widths come from the shared package (WORD_W=32, HALF_W=16).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand pair on A/B is offered.
REQ-005 in_ready  output  1  block accepts the operand pair this cycle.
REQ-006 A  input  32  minuend, unsigned / two's complement.
REQ-007 B  input  32  subtrahend.
REQ-008 out_valid  output  1  D and the flags hold a valid result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 D  output  32  difference A-B, modulo 2^32.
REQ-011 B32  output  1  borrow out; 1 exactly when A < B unsigned.
REQ-012 V  output  1  signed overflow; (A[31]!=B[31]) && (D[31]!=A[31]).
REQ-013 Z  output  1  1 when D == 0.

Function
REQ-014 Arithmetic SHALL be D = A + ~B + 1, computed in two 16-bit halves. Internal carry c16 comes from the low half; B32 = ~c32.
REQ-015 A transfer in SHALL occur on an edge where in_valid && in_ready. A transfer out SHALL occur on an edge where out_valid && out_ready.
REQ-016 Stage 1 SHALL register the following on accept:
- low difference D[15:0]
- c16
- A[31:16], B[31:16]
- s1_valid
REQ-017 Stage 2 SHALL compute the upper half with carry-in c16, and SHALL register D, B32, V, Z and out_valid.
REQ-018 Latency: a pair accepted at edge k SHALL give out_valid=1 after edge k+1, with the result visible in the cycle following that edge (2-stage pipe).
REQ-019 Throughput SHALL be one result per cycle while out_ready=1.
REQ-020 Stage-2 advance condition s2_adv = !out_valid || out_ready.
REQ-021 in_ready SHALL equal !s1_valid || s2_adv, combinationally. It SHALL NOT depend on in_valid.
REQ-022 When out_valid && !out_ready, D, B32, V and Z SHALL hold stable. When stage 1 is also full, in_ready SHALL be 0 and no operand is lost or duplicated.
REQ-023 Stage 1 SHALL move into stage 2 when s2_adv && s1_valid. If no new input arrives in the same cycle, s1_valid SHALL clear.
REQ-024 Simultaneous out-transfer and in-transfer with both stages full SHALL shift the pipeline, keeping it full.
REQ-025 Wrap-around: results SHALL be truncated to 32 bits with no saturation. 0x00000000-0x00000001 SHALL give D=0xFFFFFFFF, B32=1.
REQ-026 Data and flag outputs SHALL be don't-care-free: they retain their last value while out_valid=0.

Reset
REQ-027 While rst_n=0 at a rising edge:
- s1_valid and out_valid SHALL be 0.
- D SHALL be 0x00000000.
- B32=0, V=0, Z=1 (consistent with D=0).
REQ-028 Reset mid-operation SHALL discard all in-flight operands. in_ready SHALL read 1 in the first cycle after reset deasserts.
REQ-029 No asynchronous reset path SHALL exist.

Structure
REQ-030 Package sub_pkg SHALL hold WORD_W, HALF_W, and a struct for the stage-1 register set (lo_diff, c16, a_hi, b_hi).
REQ-031 The block SHALL instantiate sub-module sub_slice_16 twice. sub_slice_16 is combinational, with ports a[15:0], b[15:0], cin, diff[15:0], cout, and computes a + ~b + cin.
REQ-032 Pipeline control (REQ-020..024) SHALL live in subtractor_32bit only.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- A=5, B=3, out_ready=1 -> two cycles later D=0x00000002, B32=0, V=0, Z=0.
- A=0x00010000, B=0x00000001 -> D=0x0000FFFF, B32=0; checks borrow across halves.
- A=0x80000000, B=0x00000001 -> D=0x7FFFFFFF, V=1, B32=0. Then A=B=0x1234ABCD -> D=0, Z=1.
- Four back-to-back pairs with out_ready=0 for 3 cycles:
  - in_ready drops after 2 accepts.
  - Outputs stay stable.
  - On release, all four results emerge in order with no gaps.
- Reset asserted with both stages full -> out_valid=0 and D=0 next cycle. No stale result ever appears after reset.
